forward_vertical_merge: RTL
===========================

Name: forward_vertical_merge

Overview:
- Vertical forwarding stage of a router, directly downstream of the forward-east/forward-west path decoders.
- Buffers packets that have already resolved their horizontal offset: one FIFO each for the east-lane decoder, the west-lane decoder and the vertical neighbour router.
- A round-robin arbiter picks one packet per cycle and either:
  - forwards it vertically with dy stepped by ADD, or
  - ejects it to the local port when dy==0.
- Instantiated twice per router: north with ADD=-1, south with ADD=1.

Parameters:
- DATA_WIDTH, 23, packet width after dx removal.
- DY_MSB, 20, MSB of the signed dy field.
- DY_LSB, 12, LSB of the dy field.
- ADD, -1, value added to dy on vertical forward (-1 north, +1 south).
- BUFFER_DEPTH, 4, entries per input FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- din_e  in  DATA_WIDTH  packet from the east-lane decoder.
- wen_e  in  1  write strobe for din_e.
- full_e  out  1  east FIFO full.
- din_w  in  DATA_WIDTH  packet from the west-lane decoder.
- wen_w  in  1  write strobe for din_w.
- full_w  out  1  west FIFO full.
- din_v  in  DATA_WIDTH  packet from the vertical neighbour router.
- wen_v  in  1  write strobe for din_v.
- full_v  out  1  vertical FIFO full.
- dout_v  out  DATA_WIDTH  packet to the next router vertically, dy already stepped.
- wen_out_v  out  1  one-cycle valid for dout_v.
- full_out_v  in  1  downstream router input full.
- dout_local  out  DATA_WIDTH  packet ejected to the local core, unchanged.
- wen_local  out  1  one-cycle valid for dout_local.
- full_local  in  1  local sink full.

Behaviour:
- Reset: clk and rst as decided above (one clock, synchronous active-high reset).
  - All FIFOs empty; full_* = 0.
  - dout_v and dout_local = 0; wen_out_v and wen_local = 0.
  - Round-robin pointer = east.
  - Reset mid-operation discards all buffered packets; no output strobe in the cycle after rst.
- FIFO write: on a clk edge with wen_x=1 and full_x=0, din_x is pushed. A write while full_x=1 is ignored (upstream protocol violation; no corruption).
- full_x: registered, asserted when count==BUFFER_DEPTH. A pop in the same cycle as a full-write does not admit that write.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Head routing per FIFO:
  - dy (signed) == 0 → local request.
  - otherwise → vertical request.
- Eligibility: a request is eligible only if its target's full input is 0, sampled in the arbitration cycle.
- Arbitration:
  - Round-robin over the order e→w→v, starting at the pointer.
  - At most one grant per target per cycle.
  - One local grant and one vertical grant may issue in the same cycle from different FIFOs, each by independent round-robin order from the same pointer.
  - Pointer advances to the FIFO after the last granted FIFO (vertical grant takes precedence when both issue).
- Head-of-line: a blocked head stalls only its own FIFO; other FIFOs proceed.
- Output: granted packets are registered.
  - dout_v = packet with dy replaced by dy+ADD, computed at dy width with wrap-around; all other bits unchanged.
  - dout_local = packet unchanged.
  - wen strobes are high for exactly one cycle per packet. dout holds its last value when wen is low.
- Latency: write at edge N into an empty FIFO, with the target free → wen_* high after edge N+1.
- Throughput: up to 2 packets/cycle total (1 vertical + 1 local).

Test Plan:
- Single vertical forward: ADD=-1, write din_e with dy=2 (bits[20:12]=9'd2), payload 0x5A5 → dout_v has dy=1, payload 0x5A5, wen_out_v high 2 edges later; wen_local stays 0.
- Local eject: din_w with dy=0 → wen_local one cycle, dout_local==din_w bit-exact; wen_out_v=0.
- Contention: same cycle write e(dy=1), w(dy=3), v(dy=5) with outputs free → vertical outputs in order e, w, v on 3 consecutive cycles (dy 0, 2, 4); repeat → order continues rotating fairly.
- Backpressure: hold full_out_v=1, write 5 vertical packets to e → full_e asserts after 4th, 5th dropped; release → exactly 4 packets out in order. A west dy=0 packet still ejects locally during the stall.
- Dual issue: e holds dy=0, v holds dy=-1 (ADD=1 instance) → wen_local and wen_out_v both high on the same cycle; dout_v dy=0.
- Reset mid-operation: fill all FIFOs, assert rst one cycle → no strobes afterwards, full_*=0, a subsequent single write emerges with latency 2.

Source files
------------

// File: rtl/forward_vertical_merge.sv
// Vertical merge stage: buffers east/west/vertical packets in three FIFOs,
// then round-robin arbitrates them onto a vertical output (dy stepped by ADD)
// and a local eject port (dy == 0).
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   din_e/wen_e/full_e          - east-lane decoder input FIFO
//   din_w/wen_w/full_w          - west-lane decoder input FIFO
//   din_v/wen_v/full_v          - vertical neighbour input FIFO
//   dout_v/wen_out_v/full_out_v - registered vertical output, dy stepped by ADD
//   dout_local/wen_local/full_local - registered local eject, packet unchanged
module forward_vertical_merge #(
  parameter int DATA_WIDTH   = 23,
  parameter int DY_MSB       = 20,
  parameter int DY_LSB       = 12,
  parameter int ADD          = -1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_e,
  input  logic                  wen_e,
  output logic                  full_e,
  input  logic [DATA_WIDTH-1:0] din_w,
  input  logic                  wen_w,
  output logic                  full_w,
  input  logic [DATA_WIDTH-1:0] din_v,
  input  logic                  wen_v,
  output logic                  full_v,
  output logic [DATA_WIDTH-1:0] dout_v,
  output logic                  wen_out_v,
  input  logic                  full_out_v,
  output logic [DATA_WIDTH-1:0] dout_local,
  output logic                  wen_local,
  input  logic                  full_local
);

  localparam int DYW = DY_MSB - DY_LSB + 1;
  localparam int PW  = $clog2(BUFFER_DEPTH);
  localparam logic [DYW-1:0] ADD_C   = DYW'(ADD);
  localparam logic [PW:0]    DEPTH_C = (PW+1)'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] din  [3];
  logic [DATA_WIDTH-1:0] head [3];
  logic [2:0] wen;
  logic [2:0] full;
  logic [2:0] pop;
  logic [2:0] req_v;
  logic [2:0] req_l;

  assign din[0] = din_e;
  assign din[1] = din_w;
  assign din[2] = din_v;
  assign wen    = {wen_v, wen_w, wen_e};
  assign full_e = full[0];
  assign full_w = full[1];
  assign full_v = full[2];

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full_q;
    logic          push;
    logic          nempty;
    logic [DYW-1:0] dy;

    // A pop in the same cycle does not free a slot for a full-write.
    assign push   = wen[g] & ~full_q;
    assign nempty = (cnt_q != '0);
    assign head[g] = mem_q[rd_q];
    assign full[g] = full_q;
    assign dy      = head[g][DY_MSB:DY_LSB];

    assign req_l[g] = nempty & (dy == '0) & ~full_local;
    assign req_v[g] = nempty & (dy != '0) & ~full_out_v;

    always_comb begin
      cnt_d = cnt_q;
      if (push & ~pop[g])
        cnt_d = cnt_q + (PW+1)'(1);
      else if (~push & pop[g])
        cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        if (push)   wr_q <= wr_q + PW'(1);
        if (pop[g]) rd_q <= rd_q + PW'(1);
        cnt_q  <= cnt_d;
        full_q <= (cnt_d == DEPTH_C);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din[g];
    end
  end

  logic [1:0] rr_q, rr_d;
  logic [1:0] sel_v, sel_l;
  logic       fnd_v, fnd_l;
  logic [2:0] sum;
  logic [1:0] idx;
  logic [DATA_WIDTH-1:0] pkt_v;

  // Both targets scan e->w->v from the same pointer; a head requests only
  // one target, so the two winners always come from different FIFOs.
  always_comb begin
    fnd_v = 1'b0;
    fnd_l = 1'b0;
    sel_v = '0;
    sel_l = '0;
    sum   = '0;
    idx   = '0;
    pop   = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!fnd_v && req_v[idx]) begin
        fnd_v = 1'b1;
        sel_v = idx;
      end
      if (!fnd_l && req_l[idx]) begin
        fnd_l = 1'b1;
        sel_l = idx;
      end
    end
    if (fnd_v) pop[sel_v] = 1'b1;
    if (fnd_l) pop[sel_l] = 1'b1;
  end

  // Vertical winner sets the pointer when both targets issue.
  always_comb begin
    rr_d = rr_q;
    if (fnd_v)
      rr_d = (sel_v == 2'd2) ? 2'd0 : sel_v + 2'd1;
    else if (fnd_l)
      rr_d = (sel_l == 2'd2) ? 2'd0 : sel_l + 2'd1;
  end

  // dy wraps at its own field width.
  always_comb begin
    pkt_v = head[sel_v];
    pkt_v[DY_MSB:DY_LSB] = head[sel_v][DY_MSB:DY_LSB] + ADD_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      dout_v     <= '0;
      wen_out_v  <= 1'b0;
      dout_local <= '0;
      wen_local  <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      wen_out_v <= fnd_v;
      wen_local <= fnd_l;
      if (fnd_v) dout_v     <= pkt_v;
      if (fnd_l) dout_local <= head[sel_l];
    end
  end

endmodule
